// File: rtl/out_port_arbiter_pkg.sv
// Shared definitions for the output-port arbiter: flit type encodings,
// input-port indices and the arbiter state type.
package out_port_arbiter_pkg;

    localparam logic [2:0] HEADER  = 3'b001;
    localparam logic [2:0] PAYLOAD = 3'b010;
    localparam logic [2:0] TAIL    = 3'b100;

    localparam int PORT_N = 0;
    localparam int PORT_E = 1;
    localparam int PORT_W = 2;
    localparam int PORT_S = 3;
    localparam int PORT_L = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/out_port_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set candidate scanning upward from
// ptr_i, wrapping modulo NUM_IN.
module out_port_arbiter_rr_arbiter #(
    parameter int NUM_IN = 5,
    parameter int PTR_W  = 3
) (
    input  logic [NUM_IN-1:0] cand_i,
    input  logic [PTR_W-1:0]  ptr_i,
    output logic [NUM_IN-1:0] pick_o,
    output logic              any_o
);

    int               sum;
    logic [PTR_W-1:0] idx;

    always_comb begin
        pick_o = '0;
        any_o  = 1'b0;
        sum    = 0;
        idx    = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            sum = int'(ptr_i) + k;
            if (sum >= NUM_IN) begin
                sum = sum - NUM_IN;
            end
            idx = PTR_W'(sum);
            if (!any_o && cand_i[idx]) begin
                pick_o[idx] = 1'b1;
                any_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/out_port_arbiter.sv
// Output-port arbiter: round-robin packet-granular grant over the input ports,
// gated by a downstream credit counter.
module out_port_arbiter
    import out_port_arbiter_pkg::*;
#(
    parameter int NUM_IN    = 5,
    parameter int BUF_DEPTH = 4,
    parameter int CNT_W     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_IN-1:0]     req,
    input  logic [NUM_IN-1:0]     valid,
    input  logic [3*NUM_IN-1:0]   flit_id_in,
    input  logic                  credit_in,
    output logic [NUM_IN-1:0]     grant,
    output logic [NUM_IN-1:0]     rd_en,
    output logic                  flit_valid_out,
    output logic [CNT_W-1:0]      credit_cnt,
    output logic                  credit_err
);

    localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    state_e            state_q;
    logic [NUM_IN-1:0] grant_q;
    logic [PTR_W-1:0]  rr_ptr_q;
    logic [PTR_W-1:0]  rr_ptr_d;
    logic [CNT_W-1:0]  credit_q;
    logic [CNT_W-1:0]  credit_d;
    logic              credit_err_q;
    logic              credit_err_d;

    logic [NUM_IN-1:0] cand;
    logic [NUM_IN-1:0] pick;
    logic              any;
    logic [PTR_W-1:0]  g_idx;
    logic              g_valid;
    logic [2:0]        g_flit;
    logic              transfer;
    logic              tail_xfer;

    always_comb begin
        cand = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            cand[i] = req[i] & valid[i] & (flit_id_in[3*i +: 3] == HEADER);
        end
    end

    out_port_arbiter_rr_arbiter #(
        .NUM_IN (NUM_IN),
        .PTR_W  (PTR_W)
    ) u_rr (
        .cand_i (cand),
        .ptr_i  (rr_ptr_q),
        .pick_o (pick),
        .any_o  (any)
    );

    // Steer the granted input's valid and head flit out of the one-hot grant.
    always_comb begin
        g_idx   = '0;
        g_valid = 1'b0;
        g_flit  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_q[i]) begin
                g_idx   = PTR_W'(i);
                g_valid = valid[i];
                g_flit  = flit_id_in[3*i +: 3];
            end
        end
    end

    assign transfer       = (state_q == BUSY) & g_valid & (credit_q != '0);
    assign tail_xfer      = transfer & (g_flit == TAIL);
    assign rd_en          = transfer ? grant_q : '0;
    assign flit_valid_out = transfer;

    assign rr_ptr_d = (g_idx == PTR_W'(NUM_IN - 1)) ? '0 : g_idx + PTR_W'(1);

    // A return and a send in the same cycle cancel; a return into a full
    // counter is a downstream protocol error and is latched.
    always_comb begin
        credit_d     = credit_q;
        credit_err_d = credit_err_q;
        if (credit_in && !transfer) begin
            if (credit_q == CNT_W'(BUF_DEPTH)) begin
                credit_err_d = 1'b1;
            end else begin
                credit_d = credit_q + CNT_W'(1);
            end
        end else if (!credit_in && transfer) begin
            credit_d = credit_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            credit_q     <= CNT_W'(BUF_DEPTH);
            credit_err_q <= 1'b0;
        end else begin
            credit_q     <= credit_d;
            credit_err_q <= credit_err_d;
            case (state_q)
                IDLE: begin
                    if (any && (credit_q != '0)) begin
                        grant_q <= pick;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (tail_xfer) begin
                        grant_q  <= '0;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign grant      = grant_q;
    assign credit_cnt = credit_q;
    assign credit_err = credit_err_q;

endmodule
